// File: rtl/vending_machine_change.sv
// Coin-operated vend controller: accumulates nickel/dime/quarter credit against PRICE,
// strobes `open` for OPEN_CYCLES cycles, then pays overpayment back as nickel pulses.
module vending_machine_change #(
    parameter int unsigned PRICE       = 15,
    parameter int unsigned NICKEL_VAL  = 5,
    parameter int unsigned DIME_VAL    = 10,
    parameter int unsigned QUARTER_VAL = 25,
    parameter int unsigned CREDIT_W    = 6,
    parameter int unsigned OPEN_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    output logic                open,
    output logic                change_nickel,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_VEND    = 2'd1;
    localparam logic [1:0] ST_CHANGE  = 2'd2;

    localparam int unsigned OC_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

    localparam logic [CREDIT_W:0]   PRICE_W   = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] NICKEL_W  = CREDIT_W'(NICKEL_VAL);
    localparam logic [CREDIT_W-1:0] DIME_W    = CREDIT_W'(DIME_VAL);
    localparam logic [CREDIT_W-1:0] QUARTER_W = CREDIT_W'(QUARTER_VAL);
    localparam logic [OC_W-1:0]     OPEN_LAST = OC_W'(OPEN_CYCLES - 1);

    logic                nickel_r, dime_r, quarter_r, cancel_r;
    logic [1:0]          state_r, state_s;
    logic [CREDIT_W-1:0] credit_r, credit_s;
    logic [CREDIT_W-1:0] change_r, change_s;
    logic [OC_W-1:0]     cnt_r, cnt_s;
    logic                open_r, open_s;
    logic                chg_r, chg_s;
    logic                rej_r, rej_s;
    logic                busy_r, busy_s;

    logic [CREDIT_W-1:0] coin_val_s;
    logic [CREDIT_W:0]   sum_s;
    logic                any_coin_s;
    logic                multi_coin_s;

    // Input stage: every coin/cancel pulse is registered before the FSM looks at it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nickel_r  <= 1'b0;
            dime_r    <= 1'b0;
            quarter_r <= 1'b0;
            cancel_r  <= 1'b0;
        end else begin
            nickel_r  <= nickel;
            dime_r    <= dime;
            quarter_r <= quarter;
            cancel_r  <= cancel;
        end
    end

    // Coin selection and credit sum; quarter wins over dime wins over nickel.
    always_comb begin
        coin_val_s   = {CREDIT_W{1'b0}};
        any_coin_s   = nickel_r | dime_r | quarter_r;
        multi_coin_s = (quarter_r & dime_r) | (quarter_r & nickel_r) | (dime_r & nickel_r);
        if (quarter_r) begin
            coin_val_s = QUARTER_W;
        end else if (dime_r) begin
            coin_val_s = DIME_W;
        end else if (nickel_r) begin
            coin_val_s = NICKEL_W;
        end else begin
            coin_val_s = {CREDIT_W{1'b0}};
        end
        sum_s = {1'b0, credit_r} + {1'b0, coin_val_s};
    end

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_s  = state_r;
        credit_s = credit_r;
        change_s = change_r;
        cnt_s    = cnt_r;
        open_s   = 1'b0;
        chg_s    = 1'b0;
        rej_s    = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                if (cancel_r && (credit_r != {CREDIT_W{1'b0}})) begin
                    change_s = credit_r;
                    credit_s = {CREDIT_W{1'b0}};
                    state_s  = ST_CHANGE;
                    chg_s    = 1'b1;
                    rej_s    = any_coin_s;
                end else if (any_coin_s) begin
                    rej_s = multi_coin_s;
                    if (sum_s >= PRICE_W) begin
                        credit_s = {CREDIT_W{1'b0}};
                        change_s = CREDIT_W'(sum_s - PRICE_W);
                        cnt_s    = {OC_W{1'b0}};
                        open_s   = 1'b1;
                        state_s  = ST_VEND;
                    end else begin
                        credit_s = sum_s[CREDIT_W-1:0];
                    end
                end else begin
                    state_s = ST_COLLECT;
                end
            end
            ST_VEND: begin
                rej_s = any_coin_s;
                if (cnt_r == OPEN_LAST) begin
                    if (change_r != {CREDIT_W{1'b0}}) begin
                        state_s = ST_CHANGE;
                        chg_s   = 1'b1;
                    end else begin
                        state_s = ST_COLLECT;
                    end
                end else begin
                    cnt_s  = cnt_r + {{(OC_W-1){1'b0}}, 1'b1};
                    open_s = 1'b1;
                end
            end
            ST_CHANGE: begin
                // change_nickel is already high for the pulse being paid this cycle.
                rej_s = any_coin_s;
                if (change_r <= NICKEL_W) begin
                    change_s = {CREDIT_W{1'b0}};
                    state_s  = ST_COLLECT;
                end else begin
                    change_s = change_r - NICKEL_W;
                    chg_s    = 1'b1;
                end
            end
            default: begin
                state_s  = ST_COLLECT;
                change_s = {CREDIT_W{1'b0}};
                cnt_s    = {OC_W{1'b0}};
            end
        endcase
        busy_s = (state_s != ST_COLLECT);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_COLLECT;
            credit_r <= {CREDIT_W{1'b0}};
            change_r <= {CREDIT_W{1'b0}};
            cnt_r    <= {OC_W{1'b0}};
            open_r   <= 1'b0;
            chg_r    <= 1'b0;
            rej_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            credit_r <= credit_s;
            change_r <= change_s;
            cnt_r    <= cnt_s;
            open_r   <= open_s;
            chg_r    <= chg_s;
            rej_r    <= rej_s;
            busy_r   <= busy_s;
        end
    end

    assign open          = open_r;
    assign change_nickel = chg_r;
    assign coin_reject   = rej_r;
    assign credit        = credit_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_vending_machine_change.sv
// Directed bench for vending_machine_change: default instance plus a PRICE=25, OPEN_CYCLES=3 instance.
module tb_vending_machine_change;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       nickel = 1'b0, dime = 1'b0, quarter = 1'b0, cancel = 1'b0;
    logic       open, change_nickel, coin_reject, busy;
    logic [5:0] credit;
    logic       nickel3 = 1'b0, dime3 = 1'b0, quarter3 = 1'b0, cancel3 = 1'b0;
    logic       open3, change_nickel3, coin_reject3, busy3;
    logic [5:0] credit3;

    int tests_run = 0;
    int tests_failed = 0;

    // {open, change_nickel, coin_reject, busy, credit}
    logic [9:0] obs, obs3;
    assign obs  = {open, change_nickel, coin_reject, busy, credit};
    assign obs3 = {open3, change_nickel3, coin_reject3, busy3, credit3};

    always #5 clk = ~clk;

    vending_machine_change dut (
        .clk(clk), .reset(reset), .nickel(nickel), .dime(dime), .quarter(quarter),
        .cancel(cancel), .open(open), .change_nickel(change_nickel),
        .coin_reject(coin_reject), .credit(credit), .busy(busy)
    );

    vending_machine_change #(.PRICE(25), .OPEN_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .nickel(nickel3), .dime(dime3), .quarter(quarter3),
        .cancel(cancel3), .open(open3), .change_nickel(change_nickel3),
        .coin_reject(coin_reject3), .credit(credit3), .busy(busy3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic n, input logic d, input logic q, input logic c);
        nickel = n; dime = d; quarter = q; cancel = c;
        tick();
        nickel = 1'b0; dime = 1'b0; quarter = 1'b0; cancel = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        tests_run++;
        if (obs !== 10'd0) begin
            $display("FAIL reset_outputs: got %b, want %b", obs, 10'd0);
            tests_failed++;
        end
        tests_run++;
        if (obs3 !== 10'd0) begin
            $display("FAIL reset_outputs3: got %b, want %b", obs3, 10'd0);
            tests_failed++;
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_nickels;
        logic [9:0] exp [0:4];
        exp[0] = {4'b0000, 6'd5};
        exp[1] = {4'b0000, 6'd10};
        exp[2] = {4'b1001, 6'd0};
        exp[3] = {4'b0000, 6'd0};
        exp[4] = {4'b0000, 6'd0};
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (obs !== exp[0]) begin $display("FAIL nickel1: got %b, want %b", obs, exp[0]); tests_failed++; end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (obs !== exp[1]) begin $display("FAIL nickel2: got %b, want %b", obs, exp[1]); tests_failed++; end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (obs !== exp[2]) begin $display("FAIL nickel3_open: got %b, want %b", obs, exp[2]); tests_failed++; end
        for (int i = 3; i < 5; i++) begin
            tick();
            tests_run++;
            if (obs !== exp[i]) begin $display("FAIL nickel_after[%0d]: got %b, want %b", i, obs, exp[i]); tests_failed++; end
        end
    endtask

    task automatic test_quarter_change;
        logic [9:0] exp [0:4];
        exp[0] = {4'b1001, 6'd0};
        exp[1] = {4'b0101, 6'd0};
        exp[2] = {4'b0101, 6'd0};
        exp[3] = {4'b0000, 6'd0};
        exp[4] = {4'b0000, 6'd0};
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (obs !== exp[i]) begin $display("FAIL quarter_change[%0d]: got %b, want %b", i, obs, exp[i]); tests_failed++; end
        end
    endtask

    task automatic test_cancel;
        logic [9:0] exp [0:3];
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tests_run++;
        if (obs !== 10'd0) begin $display("FAIL cancel_zero_credit: got %b, want %b", obs, 10'd0); tests_failed++; end
        exp[0] = {4'b0101, 6'd0};
        exp[1] = {4'b0101, 6'd0};
        exp[2] = {4'b0000, 6'd0};
        exp[3] = {4'b0000, 6'd0};
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (obs !== {4'b0000, 6'd10}) begin $display("FAIL cancel_dime_credit: got %b, want %b", obs, {4'b0000, 6'd10}); tests_failed++; end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (obs !== exp[i]) begin $display("FAIL cancel_refund[%0d]: got %b, want %b", i, obs, exp[i]); tests_failed++; end
        end
    endtask

    task automatic test_multi_coin;
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (obs !== {4'b0010, 6'd10}) begin $display("FAIL multi_coin_reject: got %b, want %b", obs, {4'b0010, 6'd10}); tests_failed++; end
        tick();
        tests_run++;
        if (obs !== {4'b0000, 6'd10}) begin $display("FAIL multi_coin_hold: got %b, want %b", obs, {4'b0000, 6'd10}); tests_failed++; end
        // 10 + 5 hits the price exactly: vend with no change.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (obs !== {4'b1001, 6'd0}) begin $display("FAIL exact_price_open: got %b, want %b", obs, {4'b1001, 6'd0}); tests_failed++; end
        tick();
        tests_run++;
        if (obs !== 10'd0) begin $display("FAIL exact_price_done: got %b, want %b", obs, 10'd0); tests_failed++; end
    endtask

    task automatic test_reject_while_busy;
        logic [9:0] exp [0:3];
        exp[0] = {4'b0111, 6'd0};
        exp[1] = {4'b0101, 6'd0};
        exp[2] = {4'b0000, 6'd0};
        exp[3] = {4'b0000, 6'd0};
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (obs !== {4'b1001, 6'd0}) begin $display("FAIL busy_vend: got %b, want %b", obs, {4'b1001, 6'd0}); tests_failed++; end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (obs !== exp[i]) begin $display("FAIL busy_reject[%0d]: got %b, want %b", i, obs, exp[i]); tests_failed++; end
        end
    endtask

    task automatic test_open_cycles;
        logic [9:0] exp [0:4];
        exp[0] = {4'b1001, 6'd0};
        exp[1] = {4'b1001, 6'd0};
        exp[2] = {4'b1001, 6'd0};
        exp[3] = {4'b0000, 6'd0};
        exp[4] = {4'b0000, 6'd0};
        quarter3 = 1'b1;
        tick();
        quarter3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (obs3 !== exp[i]) begin $display("FAIL open_cycles3[%0d]: got %b, want %b", i, obs3, exp[i]); tests_failed++; end
        end
    endtask

    task automatic test_reset_in_change;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        tests_run++;
        if (obs !== {4'b0101, 6'd0}) begin $display("FAIL pre_reset_change: got %b, want %b", obs, {4'b0101, 6'd0}); tests_failed++; end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (obs !== 10'd0) begin $display("FAIL reset_mid_change: got %b, want %b", obs, 10'd0); tests_failed++; end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (obs !== 10'd0) begin $display("FAIL after_reset[%0d]: got %b, want %b", i, obs, 10'd0); tests_failed++; end
        end
    endtask

    initial begin
        test_reset();
        test_nickels();
        test_quarter_change();
        test_cancel();
        test_multi_coin();
        test_reject_while_busy();
        test_open_cycles();
        test_reset_in_change();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
